// File: rtl/sort4_seq_ctrl.sv
// Purpose: collects 4 samples and sorts them with one shared compare-swap unit (5-step network). Optional SORT4_SWAPCNT_EN adds swap_cnt.
// Latency: 6 clk edges from the 4th input handshake edge (inclusive) to out_valid high; busy for 5 cycles.
// Backpressure: in_ready only in LOAD; the result is held with out_valid until out_ready, with no overlap of load and unload.
module sort4_seq_ctrl #(
  parameter int DW     = 8,
  parameter int ASCEND = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] a,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] ra,
  output logic [DW-1:0] rb,
  output logic [DW-1:0] rc,
  output logic [DW-1:0] rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
`ifdef SORT4_SWAPCNT_EN
  ,
  output logic [2:0]    swap_cnt
`endif
);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] SORT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    cnt;
  logic [2:0]    step;
  logic [DW-1:0] w  [4];
  logic [DW-1:0] wn [4];
  logic [1:0]    ia;
  logic [1:0]    ib;
  logic [DW-1:0] lo;
  logic [DW-1:0] hi;
  logic          do_swap;

  assign in_ready = (state == LOAD) && !reset;
  assign busy     = (state == SORT);

  // Pair selected by the network schedule; step values past 4 never occur in SORT.
  always_comb begin
    ia = 2'd1;
    ib = 2'd2;
    case (step)
      3'd0:    begin ia = 2'd0; ib = 2'd1; end
      3'd1:    begin ia = 2'd2; ib = 2'd3; end
      3'd2:    begin ia = 2'd0; ib = 2'd2; end
      3'd3:    begin ia = 2'd1; ib = 2'd3; end
      default: begin ia = 2'd1; ib = 2'd2; end
    endcase
    lo      = w[ia];
    hi      = w[ib];
    do_swap = (ASCEND != 0) ? (lo > hi) : (lo < hi);
    for (int i = 0; i < 4; i++) wn[i] = w[i];
    if (do_swap) begin
      wn[ia] = hi;
      wn[ib] = lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      cnt       <= 2'd0;
      step      <= 3'd0;
      for (int i = 0; i < 4; i++) w[i] <= '0;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      rd        <= '0;
      out_valid <= 1'b0;
`ifdef SORT4_SWAPCNT_EN
      swap_cnt  <= 3'd0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            w[cnt] <= a;
            if (cnt == 2'd3) begin
              state    <= SORT;
              cnt      <= 2'd0;
              step     <= 3'd0;
`ifdef SORT4_SWAPCNT_EN
              swap_cnt <= 3'd0;
`endif
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        SORT: begin
          for (int i = 0; i < 4; i++) w[i] <= wn[i];
`ifdef SORT4_SWAPCNT_EN
          swap_cnt <= swap_cnt + {2'b00, do_swap};
`endif
          // The last step publishes the swapped values directly so out_valid rises on the same edge.
          if (step >= 3'd4) begin
            state     <= DONE;
            step      <= 3'd0;
            ra        <= wn[0];
            rb        <= wn[1];
            rc        <= wn[2];
            rd        <= wn[3];
            out_valid <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD;
            cnt       <= 2'd0;
          end
        end
        default: begin
          state     <= LOAD;
          cnt       <= 2'd0;
          step      <= 3'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Bench for sort4_seq_ctrl: ascending and descending instances share the same stimulus and are checked against a sort model.
module tb_sort4_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] a;
  logic       in_valid;
  logic       out_ready;

  logic       ir_a, ov_a, by_a, ir_d, ov_d, by_d;
  logic [7:0] ra_a, rb_a, rc_a, rd_a, ra_d, rb_d, rc_d, rd_d;
`ifdef SORT4_SWAPCNT_EN
  logic [2:0] sc_a, sc_d;
`endif

  int nvec = 0;
  int nerr = 0;
  int prev_lo = 0;
  int prev_hi = 0;

  sort4_seq_ctrl #(.DW(8), .ASCEND(1)) u_asc (
    .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .in_ready(ir_a),
    .ra(ra_a), .rb(rb_a), .rc(rc_a), .rd(rd_a),
    .out_valid(ov_a), .out_ready(out_ready), .busy(by_a)
`ifdef SORT4_SWAPCNT_EN
    , .swap_cnt(sc_a)
`endif
  );

  sort4_seq_ctrl #(.DW(8), .ASCEND(0)) u_dsc (
    .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .in_ready(ir_d),
    .ra(ra_d), .rb(rb_d), .rc(rc_d), .rd(rd_d),
    .out_valid(ov_d), .out_ready(out_ready), .busy(by_d)
`ifdef SORT4_SWAPCNT_EN
    , .swap_cnt(sc_d)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endfunction

`ifdef SORT4_SWAPCNT_EN
  function automatic int nswaps(input logic [31:0] v, input bit asc);
    int pa [5] = '{0, 2, 0, 1, 1};
    int pb [5] = '{1, 3, 2, 3, 2};
    logic [7:0] w [4];
    logic [7:0] t;
    int n = 0;
    for (int i = 0; i < 4; i++) w[i] = v[8*i +: 8];
    for (int s = 0; s < 5; s++) begin
      if (asc ? (w[pa[s]] > w[pb[s]]) : (w[pa[s]] < w[pb[s]])) begin
        t = w[pa[s]]; w[pa[s]] = w[pb[s]]; w[pb[s]] = t; n++;
      end
    end
    return n;
  endfunction
`endif

  // Presents samples in order, advancing only on accepted handshakes.
  task automatic send(input logic [31:0] v, input int n, input bit toggle);
    int  i = 0;
    int  g = 0;
    bit  hs;
    while (i < n && g < 200) begin
      if (toggle && g[0]) begin
        in_valid = 1'b0;
        a = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        a = v[8*i +: 8];
      end
      hs = in_valid && ir_a;
      @(posedge clk); #1;
      g++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    chk("samples_accepted", i, n);
  endtask

  task automatic run_set(input logic [31:0] v, input bit toggle, input int hold);
    logic [7:0] q[$];
    int lat = 0;
    int bc = 0;
    out_ready = (hold == 0);
    send(v, 4, toggle);
    while (!ov_a && lat < 20) begin
      if (by_a) bc++;
      chk("old_result_lo", ra_a, prev_lo);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency_edges", lat + 1, 6);
    chk("busy_cycles", bc, 5);
    chk("busy_in_done", by_a, 0);
    chk("dsc_out_valid", ov_d, 1);
    for (int i = 0; i < 4; i++) q.push_back(v[8*i +: 8]);
    q.sort();
    chk("asc_ra", ra_a, q[0]); chk("asc_rb", rb_a, q[1]);
    chk("asc_rc", rc_a, q[2]); chk("asc_rd", rd_a, q[3]);
    chk("dsc_ra", ra_d, q[3]); chk("dsc_rb", rb_d, q[2]);
    chk("dsc_rc", rc_d, q[1]); chk("dsc_rd", rd_d, q[0]);
`ifdef SORT4_SWAPCNT_EN
    chk("asc_swap_cnt", sc_a, nswaps(v, 1'b1));
    chk("dsc_swap_cnt", sc_d, nswaps(v, 1'b0));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", ov_a, 1);
      chk("hold_in_ready", ir_a, 0);
      chk("hold_ra", ra_a, q[0]);
      chk("hold_rd", rd_a, q[3]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("consumed_out_valid", ov_a, 0);
    chk("consumed_in_ready", ir_a, 1);
    prev_lo = q[0];
    prev_hi = q[3];
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = 8'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov_a, 0);
    chk("rst_busy", by_a, 0);
    chk("rst_ra", ra_a, 0); chk("rst_rb", rb_a, 0);
    chk("rst_rc", rc_a, 0); chk("rst_rd", rd_a, 0);
`ifdef SORT4_SWAPCNT_EN
    chk("rst_swap_cnt", sc_a, 0);
`endif
    reset = 1'b0;
    #1;
    chk("rst_in_ready", ir_a, 1);

    run_set(pk(200, 7, 99, 7), 1'b0, 0);
    run_set(pk(1, 2, 3, 4), 1'b0, 0);
    run_set(pk(4, 3, 2, 1), 1'b0, 0);
    run_set(pk(5, 9, 5, 1), 1'b1, 10);

    send(pk(77, 88, 0, 0), 2, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", ov_a, 0);
    chk("midrst_ra", ra_a, 0);
    chk("midrst_in_ready", ir_a, 1);
    prev_lo = 0;
    prev_hi = 0;
    run_set(pk(10, 30, 20, 40), 1'b0, 0);

    repeat (50) run_set($urandom, 1'($urandom_range(0, 1)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
